// File: rtl/sfp_accumulator.sv
// Lane-wise saturating accumulator over n_pass passes of OFIFO psum rows,
// followed by a valid/ready drain of the finished rows with optional ReLU.
module sfp_accumulator #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int cnt_bw  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               n_pass,
  input  logic [cnt_bw-1:0]        n_rows,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic [col*psum_bw-1:0]   sfp_out,
  output logic                     sfp_valid,
  input  logic                     sfp_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(depth);

  typedef logic signed [psum_bw-1:0] lane_t;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  localparam lane_t LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam lane_t LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  state_t          state_q, state_d;
  logic [AW-1:0]   row_cnt_q, row_cnt_d;
  logic [AW-1:0]   out_cnt_q, out_cnt_d;
  logic [3:0]      pass_cnt_q, pass_cnt_d;
  logic [AW-1:0]   last_row_q, last_row_d;
  logic [3:0]      last_pass_q, last_pass_d;
  logic            relu_q, relu_d;
  logic            done_q, done_d;
  lane_t           rowbuf_q [depth][col];

  logic pop;

  // Sign-extend to one extra bit; a disagreement between the top two bits
  // of the sum means overflow in the direction of the top bit.
  function automatic lane_t sat_add(input lane_t a, input lane_t b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      sat_add = s[psum_bw] ? LANE_MIN : LANE_MAX;
    else
      sat_add = lane_t'(s[psum_bw-1:0]);
  endfunction

  assign pop       = (state_q == ACC) && ofifo_valid;
  assign ofifo_rd  = pop;
  assign sfp_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    out_cnt_d   = out_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    last_row_d  = last_row_q;
    last_pass_d = last_pass_q;
    relu_d      = relu_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ACC;
          row_cnt_d   = '0;
          out_cnt_d   = '0;
          pass_cnt_d  = '0;
          relu_d      = relu_en;
          last_pass_d = (n_pass == 4'd0) ? 4'd0 : n_pass - 4'd1;
          last_row_d  = (n_rows == '0 || n_rows > cnt_bw'(depth)) ? AW'(depth - 1)
                                                                 : AW'(n_rows - 1'b1);
        end
      end
      ACC: begin
        if (pop) begin
          if (row_cnt_q == last_row_q) begin
            row_cnt_d = '0;
            if (pass_cnt_q == last_pass_q) begin
              state_d   = DRAIN;
              out_cnt_d = '0;
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (sfp_ready) begin
          if (out_cnt_q == last_row_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      out_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      last_row_q  <= '0;
      last_pass_q <= '0;
      relu_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      last_row_q  <= last_row_d;
      last_pass_q <= last_pass_d;
      relu_q      <= relu_d;
      done_q      <= done_d;
    end
  end

  // Row buffer is deliberately not reset; pass 0 always overwrites.
  always_ff @(posedge clk) begin
    if (pop && !reset) begin
      for (int unsigned k = 0; k < col; k++) begin
        rowbuf_q[row_cnt_q][k] <= (pass_cnt_q == 4'd0)
          ? lane_t'(ofifo_out[k*psum_bw +: psum_bw])
          : sat_add(rowbuf_q[row_cnt_q][k], lane_t'(ofifo_out[k*psum_bw +: psum_bw]));
      end
    end
  end

  always_comb begin
    lane_t lane_v;
    lane_v  = '0;
    sfp_out = '0;
    if (state_q == DRAIN) begin
      for (int unsigned k = 0; k < col; k++) begin
        lane_v = rowbuf_q[out_cnt_q][k];
        sfp_out[k*psum_bw +: psum_bw] = (relu_q && lane_v[psum_bw-1]) ? '0 : lane_v;
      end
    end
  end

endmodule

// File: tb/tb_sfp_accumulator.sv
// Directed bench for sfp_accumulator: lane 0 carries the scenario value,
// lanes k>0 carry constant k so their expected sum is k*passes.
module tb_sfp_accumulator;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   n_pass;
  logic [4:0]   n_rows;
  logic         relu_en;
  logic         ofifo_valid;
  logic [127:0] ofifo_out;
  logic         ofifo_rd;
  logic [127:0] sfp_out;
  logic         sfp_valid;
  logic         sfp_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  sfp_accumulator #(.col(8), .psum_bw(16), .depth(16), .cnt_bw(5)) dut (
    .clk(clk), .reset(reset), .start(start), .n_pass(n_pass), .n_rows(n_rows),
    .relu_en(relu_en), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
    .ofifo_rd(ofifo_rd), .sfp_out(sfp_out), .sfp_valid(sfp_valid),
    .sfp_ready(sfp_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_row(input int l0);
    logic [127:0] r;
    r = '0;
    r[15:0] = l0[15:0];
    for (int k = 1; k < 8; k++) r[k*16 +: 16] = 16'(k);
    return r;
  endfunction

  function automatic logic [127:0] exp_row(input int l0, input int m);
    logic [127:0] r;
    r = '0;
    r[15:0] = l0[15:0];
    for (int k = 1; k < 8; k++) r[k*16 +: 16] = 16'(k * m);
    return r;
  endfunction

  task automatic start_job(input logic [3:0] np, input logic [4:0] nr, input logic relu);
    @(negedge clk);
    n_pass = np; n_rows = nr; relu_en = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int l0);
    ofifo_valid = 1'b1;
    ofifo_out = mk_row(l0);
    @(negedge clk);
    ofifo_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; n_pass = '0; n_rows = '0; relu_en = 1'b0;
    ofifo_valid = 1'b1; ofifo_out = mk_row(123); sfp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ofifo_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sfp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl rd=%b busy=%b done=%b valid=%b required all 0", ofifo_rd, busy, done, sfp_valid);
    end
    checks++;
    if (sfp_out !== '0) begin
      errors++;
      $display("FAIL reset_out got %h required 0", sfp_out);
    end
    ofifo_valid = 1'b0;
  endtask

  task automatic test_basic;
    start_job(4'd1, 5'd4, 1'b0);
    ofifo_valid = 1'b1; ofifo_out = mk_row(1);
    #1;
    checks++;
    if (ofifo_rd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_pop rd=%b busy=%b required 1 1", ofifo_rd, busy);
    end
    @(negedge clk);
    feed(2); feed(3); feed(4);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (sfp_valid !== 1'b1 || sfp_out !== exp_row(r + 1, 1)) begin
        errors++;
        $display("FAIL basic_row%0d valid=%b got %h required %h", r, sfp_valid, sfp_out, exp_row(r + 1, 1));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sfp_valid !== 1'b0 || sfp_out !== '0) begin
      errors++;
      $display("FAIL basic_done done=%b busy=%b valid=%b out=%h required 1 0 0 0", done, busy, sfp_valid, sfp_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse done=%b required 0", done);
    end
  endtask

  task automatic test_relu;
    for (int pass_relu = 1; pass_relu >= 0; pass_relu--) begin
      start_job(4'd3, 5'd2, pass_relu[0]);
      for (int p = 0; p < 3; p++)
        for (int r = 0; r < 2; r++)
          feed(10 * p - r - 15);
      for (int r = 0; r < 2; r++) begin
        logic [127:0] e;
        e = pass_relu[0] ? exp_row(0, 3) : exp_row(-15 - 3 * r, 3);
        checks++;
        if (sfp_valid !== 1'b1 || sfp_out !== e) begin
          errors++;
          $display("FAIL relu%0d_row%0d valid=%b got %h required %h", pass_relu, r, sfp_valid, sfp_out, e);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL relu%0d_done done=%b required 1", pass_relu, done);
      end
    end
  endtask

  task automatic test_saturation;
    start_job(4'd2, 5'd2, 1'b0);
    feed(32'h7000); feed(32'h9000); feed(32'h7000); feed(32'h9000);
    checks++;
    if (sfp_out !== exp_row(32'h7FFF, 2)) begin
      errors++;
      $display("FAIL sat_pos got %h required %h", sfp_out, exp_row(32'h7FFF, 2));
    end
    @(negedge clk);
    checks++;
    if (sfp_out !== exp_row(32'h8000, 2)) begin
      errors++;
      $display("FAIL sat_neg got %h required %h", sfp_out, exp_row(32'h8000, 2));
    end
    @(negedge clk);
  endtask

  task automatic test_stalls;
    int vals [6] = '{1, 2, 3, 10, 20, 30};
    int gaps [6] = '{1, 0, 2, 0, 3, 1};
    logic [127:0] e [3];
    e[0] = exp_row(11, 2); e[1] = exp_row(22, 2); e[2] = exp_row(33, 2);
    start_job(4'd2, 5'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        ofifo_valid = 1'b0;
        ofifo_out = mk_row(999);
        start = (i == 2 && g == 0);
        n_pass = 4'd1; n_rows = 5'd1;
        #1;
        checks++;
        if (ofifo_rd !== 1'b0 || busy !== 1'b1 || sfp_valid !== 1'b0) begin
          errors++;
          $display("FAIL stall_gap%0d rd=%b busy=%b valid=%b required 0 1 0", i, ofifo_rd, busy, sfp_valid);
        end
        @(negedge clk);
        start = 1'b0;
      end
      feed(vals[i]);
    end
    sfp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (sfp_valid !== 1'b1 || sfp_out !== e[0]) begin
        errors++;
        $display("FAIL stall_hold%0d valid=%b got %h required %h", c, sfp_valid, sfp_out, e[0]);
      end
      @(negedge clk);
    end
    for (int r = 0; r < 3; r++) begin
      sfp_ready = 1'b1;
      checks++;
      if (sfp_valid !== 1'b1 || sfp_out !== e[r]) begin
        errors++;
        $display("FAIL stall_row%0d valid=%b got %h required %h", r, sfp_valid, sfp_out, e[r]);
      end
      @(negedge clk);
      if (r == 0) begin
        sfp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (sfp_out !== e[1]) begin
          errors++;
          $display("FAIL stall_mid got %h required %h", sfp_out, e[1]);
        end
      end
    end
    sfp_ready = 1'b1;
    checks++;
    if (done !== 1'b1 || sfp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done done=%b valid=%b required 1 0", done, sfp_valid);
    end
  endtask

  task automatic test_back_to_back;
    start_job(4'd1, 5'd1, 1'b0);
    feed(5);
    checks++;
    if (sfp_out !== exp_row(5, 1)) begin
      errors++;
      $display("FAIL b2b_first got %h required %h", sfp_out, exp_row(5, 1));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done done=%b required 1", done);
    end
    n_pass = 4'd1; n_rows = 5'd2; relu_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b required 1 0", busy, done);
    end
    feed(-3); feed(6);
    for (int r = 0; r < 2; r++) begin
      logic [127:0] e;
      e = (r == 0) ? exp_row(0, 1) : exp_row(6, 1);
      checks++;
      if (sfp_out !== e) begin
        errors++;
        $display("FAIL b2b_row%0d got %h required %h", r, sfp_out, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clamp;
    start_job(4'd0, 5'd0, 1'b0);
    for (int r = 0; r < 16; r++) feed(3 * r - 20);
    checks++;
    if (sfp_valid !== 1'b1 || ofifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL clamp_drain valid=%b rd=%b required 1 0", sfp_valid, ofifo_rd);
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (sfp_out !== exp_row(3 * r - 20, 1)) begin
        errors++;
        $display("FAIL clamp_row%0d got %h required %h", r, sfp_out, exp_row(3 * r - 20, 1));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL clamp_done done=%b required 1", done);
    end
  endtask

  task automatic test_midreset;
    start_job(4'd1, 5'd4, 1'b0);
    feed(100); feed(200); feed(300);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sfp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle busy=%b done=%b valid=%b required 0 0 0", busy, done, sfp_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nodone done=%b busy=%b required 0 0", done, busy);
    end
    start_job(4'd2, 5'd3, 1'b0);
    feed(7); feed(8); feed(9); feed(1); feed(1); feed(1);
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (sfp_out !== exp_row(8 + r, 2)) begin
        errors++;
        $display("FAIL midreset_row%0d got %h required %h", r, sfp_out, exp_row(8 + r, 2));
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_done done=%b required 1", done);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_relu;
    test_saturation;
    test_stalls;
    test_back_to_back;
    test_clamp;
    test_midreset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
